// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the op encoding used by the sequencer and its bench.
package pc_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NEXT   = 3'd0;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RETURN = 3'd4;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack with an occupancy count.
// Pushes while full and pops while empty are ignored.
module ret_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic [AW-1:0]    topIdx;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Push takes priority so a simultaneous request never moves the count twice.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o && !push_i;

    assign topIdx = count_q[AW-1:0] - AW'(1);
    assign dout_o = mem_q[topIdx];

    always_comb begin
        count_d = count_q;
        if (doPush) begin
            count_d = count_q + (AW+1)'(1);
        end else if (doPop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is left uninitialised; only entries below the count are ever read.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[count_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with stride advance, jump, relative branch
// and call/return through an internal return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic [OP_W-1:0]   op,
    input  logic              branch_taken,
    input  logic [WIDTH-1:0]  target,
    input  logic [WIDTH-1:0]  offset,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus_step,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             ovfErr_q;
    logic             ovfErr_d;
    logic             unfErr_q;
    logic             unfErr_d;

    logic             execute;
    logic             stackPush;
    logic             stackPop;
    logic             setOvf;
    logic             setUnf;
    logic [WIDTH-1:0] stackTop;
    logic             stackIsFull;
    logic             stackIsEmpty;
    logic [CW-1:0]    stackCount;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (stackPush),
        .pop_i   (stackPop),
        .din_i   (pc_plus_step),
        .dout_o  (stackTop),
        .full_o  (stackIsFull),
        .empty_o (stackIsEmpty),
        .count_o (stackCount)
    );

    assign execute       = en && !stall;
    assign pc            = pc_q;
    assign pc_plus_step  = pc_q + STEP;
    assign stack_empty   = (stackCount == '0);
    assign stack_full    = (stackCount == CW'(STACK_DEPTH));
    assign overflow_err  = ovfErr_q;
    assign underflow_err = unfErr_q;

    // A CALL on a full stack or RETURN on an empty one degrades to NEXT and flags it.
    always_comb begin
        pc_d      = pc_q;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        setOvf    = 1'b0;
        setUnf    = 1'b0;
        if (execute) begin
            case (op)
                OP_JUMP: pc_d = target;
                OP_BRANCH: pc_d = branch_taken ? (pc_q + offset) : pc_plus_step;
                OP_CALL: begin
                    if (!stackIsFull) begin
                        stackPush = 1'b1;
                        pc_d      = target;
                    end else begin
                        setOvf = 1'b1;
                        pc_d   = pc_plus_step;
                    end
                end
                OP_RETURN: begin
                    if (!stackIsEmpty) begin
                        stackPop = 1'b1;
                        pc_d     = stackTop;
                    end else begin
                        setUnf = 1'b1;
                        pc_d   = pc_plus_step;
                    end
                end
                default: pc_d = pc_plus_step;
            endcase
        end
        ovfErr_d = setOvf || (ovfErr_q && !clr_err);
        unfErr_d = setUnf || (unfErr_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ovfErr_q <= 1'b0;
            unfErr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ovfErr_q <= ovfErr_d;
            unfErr_q <= unfErr_d;
        end
    end

endmodule
